// File: rtl/addsub_nibble_seq_if.sv
// Operand/result handshake bundle for addsub_nibble_seq.
// master: operand source and result consumer (testbench / upstream logic).
// slave : the sequential adder/subtractor itself.
interface addsub_nibble_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             zero;
    logic             neg;
    logic             ovf;

    modport master (
        output in_valid, a, b, mode, out_ready,
        input  in_ready, out_valid, sum, carry_out, zero, neg, ovf
    );

    modport slave (
        input  in_valid, a, b, mode, out_ready,
        output in_ready, out_valid, sum, carry_out, zero, neg, ovf
    );
endinterface

// File: rtl/addsub_nibble_seq.sv
// Sequential WIDTH-bit adder/subtractor: one SLICE-bit ripple slice reused
// over NSLICE clocks, carry held in a register between slices.
// Optional macro ADDSUB_FLAGS_EN: registers zero/neg/ovf with the result;
// when undefined those outputs are tied to 0 and no flag logic is built.
//
//   state | meaning
//   IDLE  | waiting for an operand pair, in_ready high (outside reset)
//   RUN   | processing one slice per clock, LSB slice first
//   DONE  | result valid, held until out_ready
module addsub_nibble_seq #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    addsub_nibble_seq_if.slave   bus
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if ((WIDTH % SLICE) != 0 || SLICE < 2) begin : g_bad_param
        $error("addsub_nibble_seq: WIDTH must be a multiple of SLICE (SLICE >= 2)");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic [WIDTH-1:0]  sum_reg;
    logic [WIDTH-1:0]  sum_nxt;
    logic              carry_reg;
    logic              cout_reg;
    logic [IDXW-1:0]   idx;
    logic [SLICE-1:0]  a_sl;
    logic [SLICE-1:0]  b_sl;
    logic [SLICE-1:0]  s_sl;
    logic              c_sl;
    logic              last_slice;
    logic              in_ready_int;
    logic              accept;

    // in_ready is forced low for the whole time reset is asserted
    assign in_ready_int = (state == IDLE) && !rst;
    assign accept       = bus.in_valid && in_ready_int;
    assign last_slice   = (state == RUN) && (idx == IDXW'(NSLICE - 1));

    // Shared ripple slice; the current slice result is merged into the sum
    always_comb begin
        a_sl    = a_reg[idx*SLICE +: SLICE];
        b_sl    = b_reg[idx*SLICE +: SLICE];
        {c_sl, s_sl} = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry_reg};
        sum_nxt = sum_reg;
        sum_nxt[idx*SLICE +: SLICE] = s_sl;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)        state_nxt = RUN;
            RUN:     if (last_slice)    state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // Operand capture and slice-by-slice accumulation; B is pre-inverted for subtract
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            idx       <= '0;
        end else if (accept) begin
            a_reg     <= bus.a;
            b_reg     <= bus.b ^ {WIDTH{bus.mode}};
            carry_reg <= bus.mode;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            idx       <= '0;
        end else if (state == RUN) begin
            sum_reg   <= sum_nxt;
            carry_reg <= c_sl;
            idx       <= idx + IDXW'(1);
            if (last_slice) cout_reg <= c_sl;
        end
    end

`ifdef ADDSUB_FLAGS_EN
    logic zero_reg;
    logic neg_reg;
    logic ovf_reg;
    logic msb_cin;

    // Carry into the MSB recovered from the MSB sum bit and its operand bits
    assign msb_cin = a_sl[SLICE-1] ^ b_sl[SLICE-1] ^ s_sl[SLICE-1];

    // Flags are captured together with the final slice
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_reg <= 1'b0;
            neg_reg  <= 1'b0;
            ovf_reg  <= 1'b0;
        end else if (accept) begin
            zero_reg <= 1'b0;
            neg_reg  <= 1'b0;
            ovf_reg  <= 1'b0;
        end else if (last_slice) begin
            zero_reg <= (sum_nxt == '0);
            neg_reg  <= s_sl[SLICE-1];
            ovf_reg  <= msb_cin ^ c_sl;
        end
    end

    assign bus.zero = zero_reg;
    assign bus.neg  = neg_reg;
    assign bus.ovf  = ovf_reg;
`else
    assign bus.zero = 1'b0;
    assign bus.neg  = 1'b0;
    assign bus.ovf  = 1'b0;
`endif

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = (state == DONE);
    assign bus.sum       = sum_reg;
    assign bus.carry_out = cout_reg;
endmodule

// File: tb/tb_addsub_nibble_seq.sv
// Directed self-checking bench for addsub_nibble_seq (WIDTH=16, SLICE=4).
// Expected flags follow ADDSUB_FLAGS_EN: real values when defined, 0 otherwise.
module tb_addsub_nibble_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    addsub_nibble_seq_if #(.WIDTH(16)) bus();
    addsub_nibble_seq #(.WIDTH(16), .SLICE(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

`ifdef ADDSUB_FLAGS_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present an operand pair at a negedge, accept on the next posedge, then scramble inputs
    task automatic accept_op(input logic [15:0] a, input logic [15:0] b, input logic m);
        int k = 0;
        while (!bus.in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("ready_wait", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.mode     = m;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = ~a;
        bus.b        = a ^ 16'h5A5A;
        bus.mode     = ~m;
        chk("busy_ready", 32'(bus.in_ready), 32'd0);
    endtask

    // Called one negedge after the accept edge: out_valid must rise exactly after edge E+4
    task automatic wait_done(input string tag);
        repeat (3) begin
            @(negedge clk);
            chk({tag, "_early"}, 32'(bus.out_valid), 32'd0);
        end
        @(negedge clk);
        chk({tag, "_lat"}, 32'(bus.out_valid), 32'd1);
    endtask

    task automatic check_res(input string tag, input logic [15:0] s, input logic c,
                             input logic z, input logic n, input logic v);
        chk({tag, "_sum"}, 32'(bus.sum), 32'(s));
        chk({tag, "_c"},   32'(bus.carry_out), 32'(c));
        chk({tag, "_z"},   32'(bus.zero), 32'(z & FL));
        chk({tag, "_n"},   32'(bus.neg),  32'(n & FL));
        chk({tag, "_v"},   32'(bus.ovf),  32'(v & FL));
    endtask

    task automatic drain(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "_drain_ov"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_drain_ir"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic full_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic m, input logic [15:0] s, input logic c,
                           input logic z, input logic n, input logic v);
        accept_op(a, b, m);
        wait_done(tag);
        check_res(tag, s, c, z, n, v);
        drain(tag);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.mode      = 1'b0;
        bus.out_ready = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_ir", 32'(bus.in_ready), 32'd0);
        chk("rst_ov", 32'(bus.out_valid), 32'd0);
        check_res("rst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk("rel_ir", 32'(bus.in_ready), 32'd1);
        @(negedge clk);

        full_op("t1",  16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);
        full_op("t2",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        full_op("t3",  16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0);
        full_op("t4a", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1);
        full_op("t4b", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1);
        full_op("teq", 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        full_op("trp", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0);

        // back-pressure: DONE held 10 cycles, stray in_valid pulses ignored
        accept_op(16'h0005, 16'h0007, 1'b1);
        wait_done("t5");
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = i[0];
            bus.a        = 16'(i * 16'h1111);
            bus.b        = 16'h0101;
            bus.mode     = 1'b0;
            @(negedge clk);
            chk("t5_hold_ov", 32'(bus.out_valid), 32'd1);
            chk("t5_hold_ir", 32'(bus.in_ready), 32'd0);
            check_res("t5_hold", 16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        bus.in_valid = 1'b0;
        drain("t5");
        @(negedge clk);
        chk("t5_idle_ov", 32'(bus.out_valid), 32'd0);

        // reset during the second RUN cycle discards the op
        accept_op(16'h1234, 16'h4321, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_ov", 32'(bus.out_valid), 32'd0);
        chk("t6_sum", 32'(bus.sum), 32'd0);
        chk("t6_ir", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t6_rel_ir", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        full_op("t6r", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
